// File: rtl/tcp_port_encap_if.sv
// IP header + byte-wide payload stream bundle shared by the IP-layer blocks.
// The master drives the header fields, header valid and the payload beat;
// the slave drives both readies.
interface ip_intf;
  logic        ip_hdr_valid;
  logic        ip_hdr_ready;
  logic [47:0] eth_dest_mac;
  logic [47:0] eth_src_mac;
  logic [15:0] eth_type;
  logic [3:0]  ip_version;
  logic [3:0]  ip_ihl;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [15:0] ip_length;
  logic [15:0] ip_identification;
  logic [2:0]  ip_flags;
  logic [12:0] ip_fragment_offset;
  logic [7:0]  ip_ttl;
  logic [7:0]  ip_protocol;
  logic [15:0] ip_header_checksum;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [7:0]  ip_payload_axis_tdata;
  logic        ip_payload_axis_tvalid;
  logic        ip_payload_axis_tready;
  logic        ip_payload_axis_tlast;

  modport MASTER (
    output ip_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
           ip_version, ip_ihl, ip_dscp, ip_ecn, ip_length, ip_identification,
           ip_flags, ip_fragment_offset, ip_ttl, ip_protocol, ip_header_checksum,
           ip_source_ip, ip_dest_ip,
           ip_payload_axis_tdata, ip_payload_axis_tvalid, ip_payload_axis_tlast,
    input  ip_hdr_ready, ip_payload_axis_tready
  );

  modport SLAVE (
    input  ip_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
           ip_version, ip_ihl, ip_dscp, ip_ecn, ip_length, ip_identification,
           ip_flags, ip_fragment_offset, ip_ttl, ip_protocol, ip_header_checksum,
           ip_source_ip, ip_dest_ip,
           ip_payload_axis_tdata, ip_payload_axis_tvalid, ip_payload_axis_tlast,
    output ip_hdr_ready, ip_payload_axis_tready
  );
endinterface

// File: rtl/tcp_port_encap.sv
// TCP port encapsulator: takes an IP header plus a TCP port pair, re-emits the
// header with ip_length + 4 and a zeroed checksum, then emits the 4 port bytes
// (src hi, src lo, dest hi, dest lo) ahead of the untouched payload stream.
module tcp_port_encap (
  input  logic        i_clk,
  input  logic        i_rst,
  ip_intf.SLAVE       s_ip,
  ip_intf.MASTER      m_ip,
  input  logic [15:0] i_tcp_src,
  input  logic [15:0] i_tcp_dest,
  input  logic        i_tcp_ports_valid,
  output logic        o_tcp_ports_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PORTS   = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [15:0] identification;
    logic [2:0]  flags;
    logic [12:0] fragment_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
  } ip_hdr_t;

  state_e      state_q;
  logic [1:0]  cnt_q;
  ip_hdr_t     hdr_q;
  ip_hdr_t     hdr_d;
  logic [15:0] src_q;
  logic [15:0] dest_q;
  logic        hdr_accept;
  logic [7:0]  port_byte;

  // Header and ports are only ever taken together, and never while in reset.
  assign hdr_accept = (state_q == IDLE) && !i_rst &&
                      s_ip.ip_hdr_valid && i_tcp_ports_valid;

  // Gather the incoming header into one record for latching.
  always_comb begin
    hdr_d.version         = s_ip.ip_version;
    hdr_d.ihl             = s_ip.ip_ihl;
    hdr_d.dscp            = s_ip.ip_dscp;
    hdr_d.ecn             = s_ip.ip_ecn;
    hdr_d.length          = s_ip.ip_length;
    hdr_d.identification  = s_ip.ip_identification;
    hdr_d.flags           = s_ip.ip_flags;
    hdr_d.fragment_offset = s_ip.ip_fragment_offset;
    hdr_d.ttl             = s_ip.ip_ttl;
    hdr_d.protocol        = s_ip.ip_protocol;
    hdr_d.checksum        = s_ip.ip_header_checksum;
    hdr_d.source_ip       = s_ip.ip_source_ip;
    hdr_d.dest_ip         = s_ip.ip_dest_ip;
  end

  // Packet sequencing: accept, emit header, emit 4 port bytes, pass payload.
  // NOTE: state is updated with <= so every register samples pre-edge values;
  // blocking assignments here would make later reads see the new value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the latched header/ports are plain registers, so they are reset
      // too; outputs built from them are then defined from the first cycle.
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      src_q   <= '0;
      dest_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hdr_accept) begin
            hdr_q   <= hdr_d;
            src_q   <= i_tcp_src;
            dest_q  <= i_tcp_dest;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (m_ip.ip_hdr_ready) begin
            cnt_q   <= '0;
            state_q <= PORTS;
          end
        end
        PORTS: begin
          if (m_ip.ip_payload_axis_tready) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (s_ip.ip_payload_axis_tvalid && m_ip.ip_payload_axis_tready &&
              s_ip.ip_payload_axis_tlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Select the big-endian port byte for the current beat.
  always_comb begin
    case (cnt_q)
      2'd0:    port_byte = src_q[15:8];
      2'd1:    port_byte = src_q[7:0];
      2'd2:    port_byte = dest_q[15:8];
      default: port_byte = dest_q[7:0];
    endcase
  end

  // Handshake and beat outputs per state; everything is held low during reset.
  // NOTE: each output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    s_ip.ip_hdr_ready           = 1'b0;
    o_tcp_ports_ready           = 1'b0;
    s_ip.ip_payload_axis_tready = 1'b0;
    m_ip.ip_hdr_valid           = 1'b0;
    m_ip.ip_payload_axis_tvalid = 1'b0;
    m_ip.ip_payload_axis_tdata  = 8'h00;
    m_ip.ip_payload_axis_tlast  = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          s_ip.ip_hdr_ready = hdr_accept;
          o_tcp_ports_ready = hdr_accept;
        end
        HDR: begin
          m_ip.ip_hdr_valid = 1'b1;
        end
        PORTS: begin
          m_ip.ip_payload_axis_tvalid = 1'b1;
          m_ip.ip_payload_axis_tdata  = port_byte;
        end
        PAYLOAD: begin
          m_ip.ip_payload_axis_tvalid = s_ip.ip_payload_axis_tvalid;
          m_ip.ip_payload_axis_tdata  = s_ip.ip_payload_axis_tdata;
          m_ip.ip_payload_axis_tlast  = s_ip.ip_payload_axis_tlast;
          s_ip.ip_payload_axis_tready = m_ip.ip_payload_axis_tready;
        end
        default: ;
      endcase
    end
  end

  // Outgoing header: latched fields, length grown by the 4 port bytes
  // (16-bit wrap), checksum left for the IP encapsulator to fill in.
  assign m_ip.eth_dest_mac       = 48'h0;
  assign m_ip.eth_src_mac        = 48'h0;
  assign m_ip.eth_type           = 16'h0;
  assign m_ip.ip_version         = hdr_q.version;
  assign m_ip.ip_ihl             = hdr_q.ihl;
  assign m_ip.ip_dscp            = hdr_q.dscp;
  assign m_ip.ip_ecn             = hdr_q.ecn;
  assign m_ip.ip_length          = hdr_q.length + 16'd4;
  assign m_ip.ip_identification  = hdr_q.identification;
  assign m_ip.ip_flags           = hdr_q.flags;
  assign m_ip.ip_fragment_offset = hdr_q.fragment_offset;
  assign m_ip.ip_ttl             = hdr_q.ttl;
  assign m_ip.ip_protocol        = hdr_q.protocol;
  assign m_ip.ip_header_checksum = 16'h0;
  assign m_ip.ip_source_ip       = hdr_q.source_ip;
  assign m_ip.ip_dest_ip         = hdr_q.dest_ip;

  // Upstream Ethernet fields and the incoming checksum are deliberately dropped.
  logic unused_ok;
  assign unused_ok = ^{s_ip.eth_dest_mac, s_ip.eth_src_mac, s_ip.eth_type,
                       hdr_q.checksum};

endmodule

// File: doc/tcp_port_encap.md
# tcp_port_encap

Transmit-side counterpart of the TCP port decapsulator in the network processor. Accepts an IP header plus a byte-wide IP payload stream on an `ip_intf` slave and a source/destination port pair on a side channel. Emits the same packet on an `ip_intf` master with the 4-byte TCP port field (source then destination, big-endian) prepended to the payload and `ip_length` increased by 4. Sits between the TCP transmit logic and the IP encapsulator.

## Interface
- No parameters.
- `i_clk`  input  1  sole clock; all logic on its rising edge.
- `i_rst`  input  1  synchronous, active-high reset.
- `s_ip`  ip_intf.SLAVE  —  upstream IP header and payload stream. Its eth_* fields are ignored.
- `m_ip`  ip_intf.MASTER  —  downstream IP header and payload stream. eth_src_mac, eth_dest_mac and eth_type are tied to 0.
- `i_tcp_src`  input  16  TCP source port for the next packet.
- `i_tcp_dest`  input  16  TCP destination port for the next packet.
- `i_tcp_ports_valid`  input  1  port pair valid.
- `o_tcp_ports_ready`  output  1  port pair accepted; asserted only in the same cycle that `s_ip.ip_hdr_ready` is asserted.

## Operation
- FSM states: IDLE, HDR, PORTS, PAYLOAD. A 2-bit byte counter is used in PORTS.
- IDLE
  - `s_ip.ip_hdr_ready` = `o_tcp_ports_ready` = (`s_ip.ip_hdr_valid` && `i_tcp_ports_valid`). Header and ports are always consumed together.
  - On acceptance, latch all 13 IP header fields and both ports, then go to HDR.
  - All `m_ip` valids are 0 and `s_ip.ip_payload_axis_tready` is 0.
- HDR
  - `m_ip.ip_hdr_valid` = 1, driving the latched fields with these changes:
    - `ip_length` = latched length + 4, 16-bit modulo: 0xFFFE→0x0002, 0xFFFC→0x0000.
    - `ip_header_checksum` = 0; the IP encapsulator recomputes it.
  - All other fields pass through unchanged.
  - On `m_ip.ip_hdr_ready`, clear the counter and go to PORTS.
- PORTS
  - `m_ip.ip_payload_axis_tvalid` = 1 and `tlast` = 0.
  - `tdata` by counter value: 0 = src[15:8], 1 = src[7:0], 2 = dest[15:8], 3 = dest[7:0].
  - `s_ip.ip_payload_axis_tready` = 0.
  - The counter increments on each `m_ip` tready. On the counter==3 beat with tready, go to PAYLOAD.
- PAYLOAD
  - Combinational passthrough: m tvalid/tdata/tlast = s tvalid/tdata/tlast, and s tready = m tready.
  - A beat with tvalid && tready && tlast returns the FSM to IDLE.
- At least one payload beat is required. A zero-length TCP payload is not supported, and PAYLOAD waits indefinitely for a beat.
- There is no reordering or buffering of payload. Only one packet is in flight at a time.

## Timing
- Reset: state is IDLE, counter is 0, latched registers are 0.
  - During reset, all outputs are 0: `m_ip.ip_hdr_valid`, `m_ip.ip_payload_axis_tvalid`, `tlast`, `tdata`, `s_ip.ip_hdr_ready`, `s_ip.ip_payload_axis_tready`, `o_tcp_ports_ready`.
- Header latency: `m_ip.ip_hdr_valid` rises the cycle after the IDLE acceptance.
- The first port byte is offered the cycle after the `m_ip` header handshake.
- The first payload byte is offered the cycle after the 4th port-byte handshake.
- Payload adds zero latency. With no backpressure, a packet of N payload bytes takes 1 (accept) + 1 (hdr) + 4 + N cycles.
- Handshake rules:
  - `m_ip` valid is never deasserted, and data never changes, while ready is low. Backpressure in HDR/PORTS holds fields and byte stable.
  - Ports and header presented in different cycles: nothing is accepted until both valids are high together.
- Reset mid-packet: return to IDLE immediately, abandoning the partial output packet. Upstream must also be reset.

## Test plan
- Basic packet: src 0x1234, dest 0x0050, ip_length 0x001C, payload 0xAA,0xBB,0xCC (last on 0xCC), no backpressure.
  - Output: ip_length 0x0020, checksum 0, payload 0x12,0x34,0x00,0x50,0xAA,0xBB,0xCC with tlast only on 0xCC.
  - First port byte appears 2 cycles after header acceptance.
- Random `m_ip` ready toggling (≈50%) on the same packet: identical byte sequence, no drops or duplicates, and data stable while valid && !ready.
- Ports valid 5 cycles before header valid:
  - No acceptance until both are high.
  - `o_tcp_ports_ready` and `s_ip.ip_hdr_ready` assert in the same single cycle.
- Length wrap: ip_length 0xFFFE → output 0x0002.
- Two back-to-back packets (ports 0x0001/0x0002, then 0x0003/0x0004, 1-byte payloads): each output carries its own ports. The second header is not accepted before the first tlast completes.
- Assert `i_rst` during the 2nd port byte: all outputs go to 0 the next cycle, and a following packet is encapsulated correctly from IDLE.
